// File: rtl/hex_scroll_display_if.sv
// ---------------------------------------------------------------------------
// hex_scroll_display_if
// Groups the board-side pins of hex_scroll_display.
//   switch : slide switches (asynchronous to clk)
//   key    : two pushbuttons, active-low
//   leds   : LED bar, active-high
//   hex    : seven-segment digits, active-low, digit i at [8i+7:8i]
// Modports:
//   master : board / testbench side (drives switch and key)
//   slave  : display block side (drives leds and hex)
// ---------------------------------------------------------------------------
interface hex_scroll_display_if #(
    parameter int NUM_DIGITS = 6,
    parameter int SW_WIDTH   = 10
);
    logic [SW_WIDTH-1:0]     switch;
    logic [1:0]              key;
    logic [SW_WIDTH-1:0]     leds;
    logic [8*NUM_DIGITS-1:0] hex;

    modport master (output switch, output key, input leds, input hex);
    modport slave  (input switch, input key, output leds, output hex);
endinterface

// File: rtl/hex_scroll_display.sv
// ---------------------------------------------------------------------------
// hex_scroll_display
// Front end for a bank of seven-segment digits and an LED bar. It has three
// modes, advanced by key[0]:
//   LIVE   - digits show the switch nibbles, LEDs mirror the switches
//   MSG    - digits show the first entries of a nibble message buffer
//   SCROLL - the message scrolls leftmost-first, one step per TICK_DIV clocks
// In LIVE, key[1] appends switch[3:0] to the buffer. In SCROLL, key[1]
// toggles pause. Keys are synchronised and debounced internally.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of hex_scroll_display_if (switch, key, leds, hex)
// ---------------------------------------------------------------------------
module hex_scroll_display #(
    parameter int NUM_DIGITS      = 6,
    parameter int SW_WIDTH        = 10,
    parameter int MSG_LEN         = 16,
    parameter int TICK_DIV        = 12500000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hex_scroll_display_if.slave  bus
);
    localparam int PTR_W      = $clog2(MSG_LEN);
    localparam int CNT_W      = PTR_W + 1;
    localparam int TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LIVE_DIGITS = (SW_WIDTH + 3) / 4;
    localparam int LIVE_BITS  = 4 * LIVE_DIGITS;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_MSG    = 2'd1,
        MODE_SCROLL = 2'd2
    } mode_t;

    function automatic logic [7:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: f_glyph = 8'hC0;
            4'h1: f_glyph = 8'hF9;
            4'h2: f_glyph = 8'hA4;
            4'h3: f_glyph = 8'hB0;
            4'h4: f_glyph = 8'h99;
            4'h5: f_glyph = 8'h92;
            4'h6: f_glyph = 8'h82;
            4'h7: f_glyph = 8'hF8;
            4'h8: f_glyph = 8'h80;
            4'h9: f_glyph = 8'h90;
            4'hA: f_glyph = 8'h88;
            4'hB: f_glyph = 8'h83;
            4'hC: f_glyph = 8'hC6;
            4'hD: f_glyph = 8'hA1;
            4'hE: f_glyph = 8'h86;
            default: f_glyph = 8'h8E;
        endcase
    endfunction

    // ---------------- input synchronisers ----------------
    logic [SW_WIDTH-1:0] r_sw_meta, r_sw_sync;
    logic [1:0]          r_key_meta, r_key_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_key_meta <= 2'b11;   // released
            r_key_sync <= 2'b11;
        end else begin
            r_sw_meta  <= bus.switch;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= bus.key;
            r_key_sync <= r_key_meta;
        end
    end

    logic [LIVE_BITS-1:0] w_sw_ext;
    assign w_sw_ext = LIVE_BITS'(r_sw_sync);

    // ---------------- debounce ----------------
    // The counter only runs while the synchronised level disagrees with the
    // debounced level; any agreement restarts the qualification window.
    wire [1:0] w_press;

    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic [DB_W-1:0] r_db_cnt;
        logic            r_db_level;
        logic            r_press;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_db_cnt   <= '0;
                r_db_level <= 1'b1;
                r_press    <= 1'b0;
            end else begin
                r_press <= 1'b0;
                if (r_key_sync[gi] == r_db_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db_cnt   <= '0;
                    r_db_level <= r_key_sync[gi];
                    r_press    <= ~r_key_sync[gi];   // only a flip to pressed
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    logic w_adv, w_key1;
    assign w_adv  = w_press[0];
    assign w_key1 = w_press[1] & ~w_press[0];   // simultaneous: key[0] wins

    // ---------------- mode FSM ----------------
    mode_t r_mode, w_mode_next;
    logic  w_enter_scroll;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_mode <= MODE_LIVE;
        else          r_mode <= w_mode_next;
    end

    always_comb begin
        w_mode_next    = r_mode;
        w_enter_scroll = 1'b0;
        if (w_adv) begin
            case (r_mode)
                MODE_LIVE: w_mode_next = MODE_MSG;
                MODE_MSG: begin
                    w_mode_next    = MODE_SCROLL;
                    w_enter_scroll = 1'b1;
                end
                default:   w_mode_next = MODE_LIVE;
            endcase
        end
    end

    // ---------------- message buffer and scroll state ----------------
    logic [3:0]        r_buf [MSG_LEN];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_offset;
    logic [TICK_W-1:0] r_tick;
    logic              r_paused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MSG_LEN; i++) r_buf[i] <= 4'h0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_offset <= '0;
            r_tick   <= '0;
            r_paused <= 1'b0;
        end else begin
            if (w_enter_scroll) begin
                r_offset <= '0;
                r_tick   <= '0;
                r_paused <= 1'b0;
            end else if (r_mode == MODE_SCROLL) begin
                if (w_key1) r_paused <= ~r_paused;
                // The pause state before this clock decides whether it counts.
                if (!r_paused && r_count != '0) begin
                    if (r_tick == TICK_W'(TICK_DIV - 1)) begin
                        r_tick <= '0;
                        if ({1'b0, r_offset} == r_count - 1'b1) r_offset <= '0;
                        else                                  r_offset <= r_offset + 1'b1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
            end

            // Write pointer wraps naturally (MSG_LEN is a power of two), so
            // a full buffer is overwritten oldest-first.
            if (r_mode == MODE_LIVE && w_key1) begin
                r_buf[r_wr_ptr] <= w_sw_ext[3:0];
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_count != CNT_W'(MSG_LEN)) r_count <= r_count + 1'b1;
            end
        end
    end

    // ---------------- display generation ----------------
    wire [8*NUM_DIGITS-1:0] w_hex_next;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        // Position counted from the leftmost digit.
        localparam int J = NUM_DIGITS - 1 - gi;

        logic [3:0]       w_live_nib;
        logic             w_live_on;
        logic             w_shown;
        logic [31:0]      w_sum;
        logic [31:0]      w_wrapped;
        logic [PTR_W-1:0] w_msg_idx;
        logic [PTR_W-1:0] w_scr_idx;
        logic [7:0]       w_glyph;

        if (gi < LIVE_DIGITS) begin : g_live
            assign w_live_nib = w_sw_ext[4*gi +: 4];
            assign w_live_on  = 1'b1;
        end else begin : g_blank
            assign w_live_nib = 4'h0;
            assign w_live_on  = 1'b0;
        end

        assign w_shown   = (32'(J) < 32'(r_count));
        assign w_msg_idx = PTR_W'(J);
        // offset < count and J < count whenever shown, so one subtraction
        // is a complete modulo.
        assign w_sum     = 32'(r_offset) + 32'(J);
        assign w_wrapped = (w_sum >= 32'(r_count)) ? (w_sum - 32'(r_count)) : w_sum;
        assign w_scr_idx = PTR_W'(w_wrapped);

        always_comb begin
            w_glyph = 8'hFF;
            case (r_mode)
                MODE_LIVE:   if (w_live_on) w_glyph = f_glyph(w_live_nib);
                MODE_MSG:    if (w_shown)   w_glyph = f_glyph(r_buf[w_msg_idx]);
                MODE_SCROLL: if (w_shown)   w_glyph = f_glyph(r_buf[w_scr_idx]);
                default:     w_glyph = 8'hFF;
            endcase
        end

        assign w_hex_next[8*gi +: 8] = w_glyph;
    end

    // ---------------- LED generation ----------------
    wire  [SW_WIDTH-1:0] w_therm;
    logic [SW_WIDTH-1:0] w_leds_next;

    for (genvar gi = 0; gi < SW_WIDTH; gi++) begin : g_therm
        assign w_therm[gi] = (32'(gi) < 32'(r_count));
    end

    always_comb begin
        w_leds_next = w_therm;
        if (r_mode == MODE_LIVE)
            w_leds_next = r_sw_sync;
        else if (r_mode == MODE_SCROLL && r_paused)
            w_leds_next[SW_WIDTH-1] = 1'b1;
    end

    // ---------------- output registers ----------------
    logic [SW_WIDTH-1:0]     r_leds;
    logic [8*NUM_DIGITS-1:0] r_hex;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds <= '0;
            r_hex  <= '1;
        end else begin
            r_leds <= w_leds_next;
            r_hex  <= w_hex_next;
        end
    end

    assign bus.leds = r_leds;
    assign bus.hex  = r_hex;

endmodule

// File: tb/tb_hex_scroll_display.sv
// ---------------------------------------------------------------------------
// tb_hex_scroll_display
// Directed bench for hex_scroll_display with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too. Expected values are hand-derived cycle counts from the rising edge on
// which a key press begins (edge 0 of a press).
// ---------------------------------------------------------------------------
module tb_hex_scroll_display;
    localparam int ND = 6;
    localparam int SW = 10;
    localparam logic [47:0] ALL_BLANK = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   np, fp;

    hex_scroll_display_if #(.NUM_DIGITS(ND), .SW_WIDTH(SW)) bus ();

    hex_scroll_display #(
        .NUM_DIGITS(ND), .SW_WIDTH(SW), .MSG_LEN(16),
        .TICK_DIV(8), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the keys in mask low for len clocks, observe 20 clocks in total,
    // counting debounced press pulses of key index watch.
    task automatic press(input logic [1:0] mask, input int len, input int watch,
                         output int npulse, output int first);
        npulse = 0;
        first  = -1;
        bus.key = ~mask;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == len) bus.key = 2'b11;
            if (dut.w_press[watch]) begin
                npulse++;
                if (first < 0) first = c;
            end
        end
    endtask

    initial begin
        bus.key    = 2'b11;
        bus.switch = 10'h2A5;

        // 1. Reset and LIVE readout latency
        cyc(3);
        chk("rst_hex", bus.hex, ALL_BLANK);
        chk("rst_leds", bus.leds, 10'h000);
        reset_n = 1'b1;
        cyc(2);
        chk("live_lat2", bus.hex, 48'hFFFFFF_C0C0C0);
        cyc(1);
        chk("live_hex", bus.hex, 48'hFFFFFF_A48892);
        chk("live_leds", bus.leds, 10'h2A5);

        // 2. Debounce: short glitch ignored, long press gives one event at 6
        press(2'b01, 3, 0, np, fp);
        chk("glitch_pulses", np, 0);
        chk("glitch_mode", bus.hex, 48'hFFFFFF_A48892);
        press(2'b01, 10, 0, np, fp);
        chk("press_pulses", np, 1);
        chk("press_delay", fp, 6);
        chk("msg_empty_hex", bus.hex, ALL_BLANK);
        chk("msg_empty_leds", bus.leds, 10'h000);

        // 3. Back to LIVE (via SCROLL), load 1,2,3, then MSG
        press(2'b01, 8, 0, np, fp);
        press(2'b01, 8, 0, np, fp);
        chk("back_live", bus.hex, 48'hFFFFFF_A48892);
        for (int v = 1; v <= 3; v++) begin
            bus.switch = 10'(v);
            cyc(3);
            press(2'b10, 8, 1, np, fp);
            chk("load_pulse", np, 1);
        end
        press(2'b01, 8, 0, np, fp);
        chk("msg3_hex", bus.hex, 48'hF9A4B0_FFFFFF);
        chk("msg3_leds", bus.leds, 10'h007);

        // 4. SCROLL: mode changes at edge 7, offset steps at edges 15,23,31...
        press(2'b01, 8, 0, np, fp);                 // ends at edge 20
        chk("scr_off1", bus.hex, 48'hA4B0F9_FFFFFF);
        chk("scr_leds", bus.leds, 10'h007);
        cyc(3);                                     // edge 23
        chk("scr_off1_hold", bus.hex, 48'hA4B0F9_FFFFFF);
        cyc(1);                                     // edge 24
        chk("scr_off2", bus.hex, 48'hB0F9A4_FFFFFF);
        cyc(8);                                     // edge 32
        chk("scr_off0", bus.hex, 48'hF9A4B0_FFFFFF);
        cyc(2);                                     // edge 34
        // pause pulse at edge 40, paused from edge 41 with offset 1, tick 2
        press(2'b10, 8, 1, np, fp);                 // ends at edge 54
        chk("pause_hex", bus.hex, 48'hA4B0F9_FFFFFF);
        chk("pause_leds", bus.leds, 10'h207);
        cyc(16);                                    // edge 70
        chk("pause_hold", bus.hex, 48'hA4B0F9_FFFFFF);
        // resume at edge 77; tick 2->7 by edge 82, offset 2 at edge 83
        press(2'b10, 8, 1, np, fp);                 // ends at edge 90
        chk("resume_hex", bus.hex, 48'hB0F9A4_FFFFFF);
        chk("resume_leds", bus.leds, 10'h007);
        cyc(1);
        chk("resume_hold", bus.hex, 48'hB0F9A4_FFFFFF);
        cyc(1);
        chk("resume_step", bus.hex, 48'hF9A4B0_FFFFFF);

        // 5. Fill past capacity: 4..15, 0, then 7 overwrites entry 0
        press(2'b01, 8, 0, np, fp);                 // SCROLL -> LIVE
        for (int v = 4; v <= 17; v++) begin
            bus.switch = (v == 16) ? 10'h000 : (v == 17) ? 10'h007 : 10'(v);
            cyc(3);
            press(2'b10, 8, 1, np, fp);
        end
        chk("full_count", 64'(dut.r_count), 16);
        chk("full_wrptr", 64'(dut.r_wr_ptr), 1);
        press(2'b01, 8, 0, np, fp);                 // LIVE -> MSG
        chk("full_hex", bus.hex, 48'hF8A4B0_999282);
        chk("full_leds", bus.leds, 10'h3FF);

        // 6. Asynchronous reset in the middle of scrolling
        press(2'b01, 8, 0, np, fp);                 // MSG -> SCROLL
        cyc(5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_hex", bus.hex, ALL_BLANK);
        chk("arst_leds", bus.leds, 10'h000);
        bus.switch = 10'h003;
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        chk("post_rst_hex", bus.hex, 48'hFFFFFF_C0C0B0);
        chk("post_rst_leds", bus.leds, 10'h003);
        // Both keys at once: key[0] advances to MSG, the key[1] write is dropped
        press(2'b11, 8, 0, np, fp);
        chk("both_pulse", np, 1);
        chk("both_count", 64'(dut.r_count), 0);
        chk("both_hex", bus.hex, ALL_BLANK);
        chk("both_leds", bus.leds, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hex_scroll_display.md
Name: hex_scroll_display

Overview:
Board-level front end that drives a parametrised bank of seven-segment digits and the LED bar from switches and two pushbuttons. It succeeds the fixed-width combinational switch/key/hex board design. It adds:
- a clocked, debounced key interface
- a three-mode state machine (live switch readout, static message, scrolling message)
- a nibble message buffer that the user loads from the switches.

It sits directly under the board top level, between the pin-level switch/key inputs and the HEX/LED pins.

Parameters:
NUM_DIGITS, 6, number of seven-segment digits driven
SW_WIDTH, 10, width of switch input and LED output
MSG_LEN, 16, message buffer depth in 4-bit entries (power of two, >= 2)
TICK_DIV, 12500000, clocks per scroll step
DEBOUNCE_CYCLES, 500000, clocks a synchronised key must be stable before its debounced state changes

Ports:
clk  input  1  system clock (50 MHz on board)
reset_n  input  1  asynchronous, active-low reset
switch  input  SW_WIDTH  slide switches; asynchronous to clk, 2-FF synchronised inside
key  input  2  pushbuttons, active-low (0 = pressed); asynchronous, 2-FF synchronised inside
leds  output  SW_WIDTH  LED bar, active-high, registered
hex  output  8*NUM_DIGITS  segments, active-low, bit 7 = dp; digit i at [8i+7:8i], digit 0 rightmost; registered

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low. reset_n=0 forces all state immediately, regardless of clk.
- Reset values: mode=LIVE, buffer entries=0, wr_ptr=0, count=0, offset=0, paused=0, tick counter=0, debounced keys=released, leds=0, hex=all 8'hFF.
- Reset asserted mid-operation (mid-debounce, mid-scroll, paused) returns to the same reset state; there is no partial retention.
- Output latency: hex and leds reflect state one clock after the state changes. Switch-to-display latency in LIVE is 3 clocks (2 sync + 1 output register).

Debounce:
- Per key, a counter runs while the synchronised level differs from the debounced level. The counter clears when the levels match.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level flips.
- A released->pressed flip produces a 1-clock press pulse. Release produces no event.
- If both press pulses occur in the same clock, key[0] wins and the key[1] event is dropped.

Mode FSM (LIVE -> MSG -> SCROLL -> LIVE, advanced by a key[0] press):
- Entering SCROLL clears offset, the tick counter and paused.
- Leaving any mode keeps the buffer, count and wr_ptr.

key[1] press by mode:
- LIVE: write switch[3:0] to buffer[wr_ptr]. wr_ptr increments modulo MSG_LEN. count increments and saturates at MSG_LEN. Once full, writes overwrite the oldest entry position by position.
- MSG: no action.
- SCROLL: toggle paused.

Display encoding:
- Hex glyphs, active-low, dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. Blank is FF.

LIVE mode:
- Digit i shows switch nibble i; SW_WIDTH is zero-extended to a multiple of 4.
- Digits i >= ceil(SW_WIDTH/4) are blank.
- leds = synchronised switch.

MSG mode:
- Leftmost digit (NUM_DIGITS-1-j) shows buffer[j] for j < min(count, NUM_DIGITS). Other digits are blank.

SCROLL mode:
- Leftmost-first position j shows buffer[(offset+j) mod count] for j < min(count, NUM_DIGITS). Other positions are blank.
- When not paused and count > 0, the tick counter counts 0..TICK_DIV-1. On reaching terminal count, offset advances by 1 modulo count and the tick counter wraps to 0.
- count=0: all digits blank, offset holds at 0.
- Paused: the tick counter and offset hold.

leds in MSG/SCROLL:
- Thermometer of count: leds[i]=1 for i < count, clipped to SW_WIDTH.
- leds[SW_WIDTH-1] is overridden to 1 while paused in SCROLL.

Test Plan:
Simulation runs with DEBOUNCE_CYCLES=4, TICK_DIV=8, defaults otherwise.
1. Reset, switch=10'h2A5 -> hex=FF..FF and leds=0 during reset. Three clocks after release: hex0=92 (5), hex1=88 (A), hex2=A4 (2), hex3..5=FF, leds=10'h2A5.
2. key[0] pulsed low for 3 clocks, then for 10 clocks -> the 3-clock pulse causes no mode change. The 10-clock pulse produces exactly one press event, 6 clocks after the falling edge, and mode moves to MSG.
3. In LIVE, load switch[3:0]=1,2,3 via three key[1] presses, then enter MSG -> hex5=F9, hex4=A4, hex3=B0, hex2..0=FF, leds=10'b0000000111.
4. Enter SCROLL with count=3 -> offset steps every 8 clocks: hex5 shows 1, 2, 3, 1 ... A key[1] press freezes the display and sets leds[9]. A second press resumes from the same offset.
5. Load 17 entries -> count=16, wr_ptr=1, buffer[0] = 17th value, all 10 LEDs lit in MSG.
6. Assert reset_n mid-scroll, between clock edges -> hex=all FF and leds=0 immediately. After release the design is in LIVE with an empty buffer (MSG shows all blank).
